// File: rtl/vproc_pkg.sv
// Shared types for the vector coprocessor result path: the scheduler queue entry
// and the scheduler state.
package vproc_pkg;

  localparam int unsigned VPROC_XIF_ID_W = 3;
  localparam int unsigned VPROC_SRC_W    = 2;

  typedef struct packed {
    logic [VPROC_SRC_W-1:0]    src;
    logic [VPROC_XIF_ID_W-1:0] id;
  } result_sched_entry_t;

  typedef enum logic {
    RESULT_SCHED_RUN,
    RESULT_SCHED_DRAIN
  } result_sched_state_e;

endpackage

// File: rtl/vproc_result_sched_if.sv
// Generic valid/ready channel carrying a packed payload. The master drives
// valid and data; the slave answers with ready.
interface vproc_result_sched_if #(
  parameter int unsigned W = 5
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vproc_id_queue.sv
// DEPTH-entry circular FIFO. The write channel pushes, the read channel always
// presents the oldest entry, and a handshake on the read channel pops it.
module vproc_id_queue #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     sync_rst_i,
  vproc_result_sched_if.slave      wr,
  vproc_result_sched_if.master     rd,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wr.ready = ~w_full;
  assign rd.valid = ~w_empty;
  assign rd.data  = r_mem[r_rd_ptr];
  assign w_push   = wr.valid & wr.ready;
  assign w_pop    = rd.valid & rd.ready;
  assign count_o  = r_count;

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr.data;
  end

endmodule

// File: rtl/vproc_result_sched.sv
// In-order result scheduler: records which unit owes each issued result and
// grants the shared result channel only to the unit holding the oldest one.
module vproc_result_sched
  import vproc_pkg::*;
#(
  parameter int unsigned XIF_ID_W = 3,
  parameter int unsigned SRC_CNT  = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SRC_W    = $clog2(SRC_CNT)
) (
  input  logic                        clk_i,
  input  logic                        sync_rst_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [XIF_ID_W-1:0]         issue_id_i,
  input  logic [SRC_W-1:0]            issue_src_i,
  input  logic [SRC_CNT-1:0]          src_valid_i,
  input  logic [SRC_CNT*XIF_ID_W-1:0] src_id_i,
  output logic [SRC_CNT-1:0]          src_ready_o,
  input  logic                        res_ready_i,
  output logic                        res_valid_o,
  output logic [SRC_W-1:0]            res_src_o,
  input  logic                        drain_i,
  output logic                        drain_done_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        err_o
);

  localparam int unsigned ENTRY_W = SRC_W + XIF_ID_W;

  vproc_result_sched_if #(.W(ENTRY_W)) u_push_ch ();
  vproc_result_sched_if #(.W(ENTRY_W)) u_pop_ch ();

  result_sched_state_e     r_state;
  result_sched_state_e     w_state_nxt;
  logic                    r_err;
  logic                    w_run;
  logic [SRC_W-1:0]        w_head_src;
  logic [XIF_ID_W-1:0]     w_head_id;
  logic                    w_sel_valid;
  logic [XIF_ID_W-1:0]     w_sel_id;
  logic                    w_match;
  logic                    w_mismatch;
  logic [$clog2(DEPTH):0]  w_count;

  assign u_push_ch.valid = issue_valid_i & w_run;
  assign u_push_ch.data  = {issue_src_i, issue_id_i};
  assign issue_ready_o   = u_push_ch.ready & w_run;

  vproc_id_queue #(.W(ENTRY_W), .DEPTH(DEPTH)) u_queue (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .wr         (u_push_ch),
    .rd         (u_pop_ch),
    .count_o    (w_count)
  );

  assign count_o    = w_count;
  assign w_head_src = u_pop_ch.data[ENTRY_W-1:XIF_ID_W];
  assign w_head_id  = u_pop_ch.data[XIF_ID_W-1:0];
  assign w_sel_valid = src_valid_i[w_head_src];
  assign w_sel_id    = src_id_i[int'(w_head_src)*XIF_ID_W +: XIF_ID_W];
  assign w_match     = u_pop_ch.valid & w_sel_valid & (w_sel_id == w_head_id);
  assign w_mismatch  = u_pop_ch.valid & w_sel_valid & (w_sel_id != w_head_id);

  assign res_valid_o    = w_match;
  assign res_src_o      = w_head_src;
  assign u_pop_ch.ready = w_match & res_ready_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_ready_o = '0;
    if (w_match && res_ready_i) src_ready_o[w_head_src] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) r_err <= 1'b0;
    else            r_err <= r_err | w_mismatch;
  end
  assign err_o = r_err;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) r_state <= RESULT_SCHED_RUN;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESULT_SCHED_RUN:   if (drain_i)  w_state_nxt = RESULT_SCHED_DRAIN;
      RESULT_SCHED_DRAIN: if (!drain_i) w_state_nxt = RESULT_SCHED_RUN;
      default:            w_state_nxt = RESULT_SCHED_RUN;
    endcase
  end

  always_comb begin
    w_run        = 1'b0;
    drain_done_o = 1'b0;
    case (r_state)
      RESULT_SCHED_RUN:   w_run = 1'b1;
      RESULT_SCHED_DRAIN: drain_done_o = (w_count == '0);
      default:            w_run = 1'b0;
    endcase
  end

endmodule
